// File: rtl/dc_tile3_if.sv
// Execute-stage load/store port and L2 line port of the dc_tile3 data cache.
// Status encoding on regOutOK/memPcOK: 0=READY, 1=OK, 2=HOLD, 3=FAULT.
interface dc_tile3_if;
   logic [63:0]  regInData;
   logic [63:0]  regOutData;
   logic [31:0]  regInAddr;
   logic [1:0]   regOutOK;
   logic         regInOE;
   logic         regInWR;
   logic [4:0]   regInOp;
   logic [127:0] memInData;
   logic [127:0] memOutData;
   logic [31:0]  memPcAddr;
   logic [1:0]   memPcOK;
   logic         memPcOE;
   logic         memPcWR;
   logic [4:0]   memOp;

   // Handshake: the requester holds its request until the responder answers OK
   // (or FAULT); the requester then drops it and the responder returns to READY.
   modport slave (
      input  regInData, regInAddr, regInOE, regInWR, regInOp, memInData, memPcOK,
      output regOutData, regOutOK, memOutData, memPcAddr, memPcOE, memPcWR, memOp
   );

   modport master (
      output regInData, regInAddr, regInOE, regInWR, regInOp, memInData, memPcOK,
      input  regOutData, regOutOK, memOutData, memPcAddr, memPcOE, memPcWR, memOp
   );
endinterface

// File: rtl/dc_tile3.sv
// L1 data cache: direct-mapped, write-back, write-allocate, 64 x 128-bit lines.
// Hits answer combinationally; misses run a 4-phase writeback/fill exchange with L2.
module dc_tile3 (
   input  logic       clock,
   input  logic       reset,
   dc_tile3_if.slave  bus,
   output logic [1:0] dbgState
);
   localparam logic [1:0] ST_READY = 2'd0;
   localparam logic [1:0] ST_OK    = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, WAITR = 2'd3} state_t;

   state_t       state, stateNext;
   logic         waitFill, waitFillNext;
   logic         faultPend, faultPendNext;
   logic [27:0]  missLine, missLineNext;
   logic [63:0]  validBits, dirtyBits;
   logic [21:0]  tagArr  [64];
   logic [127:0] lineArr [64];

   logic         req, isStore, hit, victimDirty;
   logic [1:0]   size;
   logic [31:0]  alignAddr;
   logic [5:0]   idx, missIdx;
   logic [3:0]   off;
   logic [127:0] curLine, wideData, bitMask, mergedLine;
   logic [15:0]  byteEn;
   logic [63:0]  raw, loadVal;

   logic         memOeNext, memWrNext;
   logic [31:0]  memAddrNext;
   logic [127:0] memDataNext;
   logic         storeEn, fillEn, wbDone;
   logic         unusedOpBits;

   assign unusedOpBits = ^bus.regInOp[4:3];
   assign bus.memOp    = 5'h01;
   assign dbgState     = state;

   // Request decode, lookup and byte-lane steering; natural alignment keeps every access inside one line.
   always_comb begin
      size      = bus.regInOp[1:0];
      alignAddr = bus.regInAddr;
      case (size)
         2'd1:    alignAddr[0]   = 1'b0;
         2'd2:    alignAddr[1:0] = 2'b00;
         2'd3:    alignAddr[2:0] = 3'b000;
         default: ;
      endcase
      idx         = alignAddr[9:4];
      off         = alignAddr[3:0];
      curLine     = lineArr[idx];
      req         = bus.regInOE | bus.regInWR;
      isStore     = bus.regInWR;
      hit         = validBits[idx] && (tagArr[idx] == alignAddr[31:10]);
      victimDirty = validBits[idx] && dirtyBits[idx];
      missIdx     = missLine[5:0];

      raw = 64'(curLine >> {off, 3'b000});
      case (size)
         2'd0:    loadVal = bus.regInOp[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         2'd1:    loadVal = bus.regInOp[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         2'd2:    loadVal = bus.regInOp[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         default: loadVal = raw;
      endcase

      case (size)
         2'd0:    byteEn = 16'h0001;
         2'd1:    byteEn = 16'h0003;
         2'd2:    byteEn = 16'h000F;
         default: byteEn = 16'h00FF;
      endcase
      byteEn   = byteEn << off;
      wideData = {64'd0, bus.regInData} << {off, 3'b000};
      bitMask  = '0;
      for (int i = 0; i < 16; i++) bitMask[i*8 +: 8] = {8{byteEn[i]}};
      mergedLine = (curLine & ~bitMask) | (wideData & bitMask);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         waitFill       <= 1'b0;
         faultPend      <= 1'b0;
         missLine       <= '0;
         bus.memPcOE    <= 1'b0;
         bus.memPcWR    <= 1'b0;
         bus.memPcAddr  <= '0;
         bus.memOutData <= '0;
      end else begin
         state          <= stateNext;
         waitFill       <= waitFillNext;
         faultPend      <= faultPendNext;
         missLine       <= missLineNext;
         bus.memPcOE    <= memOeNext;
         bus.memPcWR    <= memWrNext;
         bus.memPcAddr  <= memAddrNext;
         bus.memOutData <= memDataNext;
      end
   end

   // WAITR remembers whether a fill still follows (after a writeback) or the miss is over.
   always_comb begin
      stateNext     = state;
      waitFillNext  = waitFill;
      faultPendNext = faultPend;
      missLineNext  = missLine;
      case (state)
         IDLE: begin
            faultPendNext = 1'b0;
            if (req && !faultPend && !hit) begin
               missLineNext = alignAddr[31:4];
               stateNext    = victimDirty ? WB : FILL;
            end
         end
         WB: begin
            if (bus.memPcOK == ST_OK) begin
               stateNext    = WAITR;
               waitFillNext = 1'b1;
            end else if (bus.memPcOK == ST_FAULT) begin
               stateNext     = WAITR;
               waitFillNext  = 1'b0;
               faultPendNext = 1'b1;
            end
         end
         FILL: begin
            if (bus.memPcOK == ST_OK) begin
               stateNext    = WAITR;
               waitFillNext = 1'b0;
            end else if (bus.memPcOK == ST_FAULT) begin
               stateNext     = WAITR;
               waitFillNext  = 1'b0;
               faultPendNext = 1'b1;
            end
         end
         default: begin
            if (bus.memPcOK != ST_OK) stateNext = waitFill ? FILL : IDLE;
         end
      endcase
   end

   always_comb begin
      bus.regOutOK   = ST_READY;
      bus.regOutData = '0;
      memOeNext      = bus.memPcOE;
      memWrNext      = bus.memPcWR;
      memAddrNext    = bus.memPcAddr;
      memDataNext    = bus.memOutData;
      storeEn        = 1'b0;
      fillEn         = 1'b0;
      wbDone         = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (faultPend) begin
                  bus.regOutOK = ST_FAULT;
               end else if (hit) begin
                  bus.regOutOK = ST_OK;
                  if (!isStore) bus.regOutData = loadVal;
                  storeEn = isStore;
               end else begin
                  bus.regOutOK = ST_HOLD;
                  if (victimDirty) begin
                     memWrNext   = 1'b1;
                     memAddrNext = {tagArr[idx], idx, 4'h0};
                     memDataNext = curLine;
                  end else begin
                     memOeNext   = 1'b1;
                     memAddrNext = {alignAddr[31:4], 4'h0};
                  end
               end
            end
         end
         WB: begin
            if (req) bus.regOutOK = ST_HOLD;
            if (bus.memPcOK == ST_OK) begin
               memWrNext = 1'b0;
               wbDone    = 1'b1;
            end else if (bus.memPcOK == ST_FAULT) begin
               memWrNext = 1'b0;
            end
         end
         FILL: begin
            if (req) bus.regOutOK = ST_HOLD;
            if (bus.memPcOK == ST_OK) begin
               memOeNext = 1'b0;
               fillEn    = 1'b1;
            end else if (bus.memPcOK == ST_FAULT) begin
               memOeNext = 1'b0;
            end
         end
         default: begin
            if (req) bus.regOutOK = ST_HOLD;
            if (bus.memPcOK != ST_OK && waitFill) begin
               memOeNext   = 1'b1;
               memAddrNext = {missLine, 4'h0};
            end
         end
      endcase
      if (reset) begin
         bus.regOutOK   = ST_READY;
         bus.regOutData = '0;
         storeEn        = 1'b0;
         fillEn         = 1'b0;
         wbDone         = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         validBits <= '0;
         dirtyBits <= '0;
      end else begin
         if (fillEn) begin
            validBits[missIdx] <= 1'b1;
            dirtyBits[missIdx] <= 1'b0;
         end
         if (wbDone)  dirtyBits[missIdx] <= 1'b0;
         if (storeEn) dirtyBits[idx]     <= 1'b1;
      end
   end

   // Line and tag storage carry no reset; the valid bits alone qualify their contents.
   always_ff @(posedge clock) begin
      if (fillEn) begin
         lineArr[missIdx] <= bus.memInData;
         tagArr[missIdx]  <= missLine[27:6];
      end else if (storeEn) begin
         lineArr[idx] <= mergedLine;
      end
   end
endmodule

// File: tb/tb_dc_tile3.sv
// Bench for dc_tile3: byte-level memory model, L2 responder with fault/stall injection,
// and a load-result queue checked when the cache answers OK.
module tb_dc_tile3;
  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_OK    = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;
  localparam int MAX_WAIT = 60;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbgState;

  dc_tile3_if bus();

  dc_tile3 dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .dbgState(dbgState)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [127:0] l2Mem[logic [31:0]];
  logic [7:0] modelMem[logic [31:0]];
  logic l2Stall = 1'b0;
  logic faultOnce = 1'b0;

  int obsWaited;
  int obsFaults;
  logic [1:0] obsFirst;
  logic obsSawOe, obsSawWr, obsBoth;
  logic [31:0] obsOeAddr, obsWrAddr;
  logic [127:0] obsWrData;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] def_byte(input logic [31:0] a);
    logic [2:0] t;
    t = a[14:12] - 3'd1;
    return {4'h0, a[3:0]} + {a[7:4], 4'h0} + {t, 5'h00};
  endfunction

  function automatic logic [127:0] l2_line(input logic [31:0] la);
    logic [127:0] l;
    if (l2Mem.exists(la)) return l2Mem[la];
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = def_byte(la + 32'(i));
    return l;
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    if (modelMem.exists(a)) return modelMem[a];
    return def_byte(a);
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = model_byte(la + 32'(i));
    return l;
  endfunction

  function automatic logic [63:0] model_load(input logic [31:0] addr, input logic [4:0] op);
    logic [31:0] a;
    logic [63:0] v;
    int n;
    n = 1 << op[1:0];
    a = addr & ~(32'(n) - 32'd1);
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = model_byte(a + 32'(i));
    if (!op[2] && n < 8 && v[n*8-1])
      for (int i = n * 8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [4:0] op, input logic [63:0] d);
    logic [31:0] a;
    int n;
    n = 1 << op[1:0];
    a = addr & ~(32'(n) - 32'd1);
    for (int i = 0; i < n; i++) modelMem[a + 32'(i)] = d[i*8 +: 8];
  endtask

  // L2: answers one cycle after a request, returns to READY once the request drops.
  initial begin
    bus.memPcOK   = ST_READY;
    bus.memInData = '0;
    forever begin
      @(negedge clock);
      if (bus.memPcOK != ST_READY) begin
        if (!bus.memPcOE && !bus.memPcWR) bus.memPcOK = ST_READY;
      end else if (!l2Stall && (bus.memPcOE || bus.memPcWR)) begin
        if (faultOnce) begin
          faultOnce = 1'b0;
          bus.memPcOK = ST_FAULT;
        end else begin
          if (bus.memPcWR) l2Mem[bus.memPcAddr] = bus.memOutData;
          else bus.memInData = l2_line(bus.memPcAddr);
          bus.memPcOK = ST_OK;
        end
      end
    end
  end

  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [4:0] op, input logic [63:0] wdata);
    logic done;
    logic [63:0] exp;
    int cyc;
    @(posedge clock); #1;
    bus.regInAddr = addr;
    bus.regInOp   = op;
    bus.regInData = wdata;
    bus.regInWR   = wr;
    bus.regInOE   = !wr;
    if (!wr) exp_q.push_back(model_load(addr, op));
    else model_store(addr, op, wdata);
    obsWaited = 0; obsFaults = 0; obsFirst = ST_READY;
    obsSawOe = 1'b0; obsSawWr = 1'b0; obsBoth = 1'b0;
    obsOeAddr = '0; obsWrAddr = '0; obsWrData = '0;
    done = 1'b0;
    cyc = 0;
    while (!done && obsWaited < MAX_WAIT) begin
      @(negedge clock); #2;
      if (cyc == 0) obsFirst = bus.regOutOK;
      cyc++;
      if (bus.memPcOE && bus.memPcWR) obsBoth = 1'b1;
      if (bus.memPcOE && !obsSawOe) begin obsSawOe = 1'b1; obsOeAddr = bus.memPcAddr; end
      if (bus.memPcWR && !obsSawWr) begin
        obsSawWr = 1'b1; obsWrAddr = bus.memPcAddr; obsWrData = bus.memOutData;
      end
      if (bus.regOutOK == ST_OK) done = 1'b1;
      else begin
        if (bus.regOutOK == ST_FAULT) obsFaults++;
        obsWaited++;
      end
    end
    if (!done) begin
      check_eq({tag, "_timeout"}, 128'(1), 128'(0));
      if (!wr) void'(exp_q.pop_back());
    end else if (!wr) begin
      exp = exp_q.pop_front();
      check_eq({tag, "_data"}, 128'(bus.regOutData), 128'(exp));
    end
    check_eq({tag, "_oewr"}, 128'(obsBoth), 128'(0));
    @(posedge clock); #1;
    bus.regInOE = 1'b0;
    bus.regInWR = 1'b0;
  endtask

  initial begin
    logic seen;
    int tagSel, idxSel, offSel;
    logic [31:0] addr;
    logic [4:0] op;
    logic wr;

    bus.regInData = '0;
    bus.regInAddr = '0;
    bus.regInOE   = 1'b0;
    bus.regInWR   = 1'b0;
    bus.regInOp   = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #2;
    check_eq("rst_regOutOK", 128'(bus.regOutOK), 128'(ST_READY));
    check_eq("rst_regOutData", 128'(bus.regOutData), 128'(0));
    check_eq("rst_memPcOE", 128'(bus.memPcOE), 128'(0));
    check_eq("rst_memPcWR", 128'(bus.memPcWR), 128'(0));
    check_eq("rst_memPcAddr", 128'(bus.memPcAddr), 128'(0));
    check_eq("rst_memOutData", bus.memOutData, 128'(0));
    check_eq("rst_memOp", 128'(bus.memOp), 128'(5'h01));

    // Clean miss, then hits on the filled line.
    access("ld1000", 1'b0, 32'h0000_1000, 5'h02, 64'd0);
    check_eq("ld1000_first", 128'(obsFirst), 128'(ST_HOLD));
    check_eq("ld1000_oeaddr", 128'(obsOeAddr), 128'(32'h0000_1000));
    check_eq("ld1000_lat", 128'(obsWaited), 128'(3));
    check_eq("ld1000_val", 128'(model_load(32'h0000_1000, 5'h02)), 128'(64'h0000_0000_0302_0100));
    access("ld64_1003", 1'b0, 32'h0000_1003, 5'h03, 64'd0);
    check_eq("ld64_lat", 128'(obsWaited), 128'(0));
    access("st1005", 1'b1, 32'h0000_1005, 5'h00, 64'h80);
    check_eq("st1005_first", 128'(obsFirst), 128'(ST_OK));
    access("lds8_1005", 1'b0, 32'h0000_1005, 5'h00, 64'd0);
    check_eq("lds8_first", 128'(obsFirst), 128'(ST_OK));
    access("ldz8_1005", 1'b0, 32'h0000_1005, 5'h04, 64'd0);
    access("ld16_1006", 1'b0, 32'h0000_1007, 5'h01, 64'd0);

    // Dirty victim at index 0: writeback of 0x1000, then fill of 0x2000.
    access("ld2000", 1'b0, 32'h0000_2000, 5'h02, 64'd0);
    check_eq("ld2000_sawwr", 128'(obsSawWr), 128'(1));
    check_eq("ld2000_wraddr", 128'(obsWrAddr), 128'(32'h0000_1000));
    check_eq("ld2000_wrbyte5", 128'(obsWrData[47:40]), 128'(8'h80));
    check_eq("ld2000_wrline", obsWrData, model_line(32'h0000_1000));
    check_eq("ld2000_oeaddr", 128'(obsOeAddr), 128'(32'h0000_2000));
    check_eq("ld2000_lat", 128'(obsWaited), 128'(5));
    access("ldz8_1005_back", 1'b0, 32'h0000_1005, 5'h04, 64'd0);
    check_eq("ldback_wr", 128'(obsSawWr), 128'(0));

    // Fault during the fill: one FAULT cycle, then a retry that succeeds.
    faultOnce = 1'b1;
    access("ld3010", 1'b0, 32'h0000_3010, 5'h02, 64'd0);
    check_eq("ld3010_faults", 128'(obsFaults), 128'(1));
    check_eq("ld3010_lat", 128'(obsWaited), 128'(7));

    for (int k = 0; k < 48; k++) begin
      tagSel = $urandom_range(1, 4);
      idxSel = $urandom_range(2, 5);
      offSel = $urandom_range(0, 15);
      addr = (32'(tagSel) << 12) | (32'(idxSel) << 4) | 32'(offSel);
      op = {2'b00, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      wr = ($urandom_range(0, 2) == 0);
      access("rnd", wr, addr, op, {$urandom, $urandom});
    end

    access("hit3010", 1'b0, 32'h0000_3010, 5'h02, 64'd0);
    check_eq("hit3010_lat", 128'(obsWaited), 128'(0));

    // Reset while a fill request is outstanding.
    l2Stall = 1'b1;
    @(posedge clock); #1;
    bus.regInAddr = 32'h0000_5000;
    bus.regInOp   = 5'h02;
    bus.regInOE   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock); #2;
      if (bus.memPcOE) seen = 1'b1;
    end
    check_eq("stall_oe", 128'(seen), 128'(1));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock); #2;
    check_eq("midrst_memPcOE", 128'(bus.memPcOE), 128'(0));
    check_eq("midrst_regOutOK", 128'(bus.regOutOK), 128'(ST_READY));
    check_eq("midrst_regOutData", 128'(bus.regOutData), 128'(0));
    check_eq("midrst_state", 128'(dbgState), 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    bus.regInOE = 1'b0;
    l2Stall = 1'b0;
    access("after_rst3010", 1'b0, 32'h0000_3010, 5'h02, 64'd0);
    check_eq("after_rst_first", 128'(obsFirst), 128'(ST_HOLD));
    check_eq("after_rst_lat", 128'(obsWaited), 128'(3));

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dc_tile3.md
Name: dc_tile3

Overview:
- L1 data cache between the execute stage's load/store port and the L2 line interface.
- Direct-mapped, write-back, write-allocate; 64 lines of 128 bits (1 KiB).
- Hits are serviced combinationally; misses run a writeback/fill handshake with L2 while the requester is held.

Parameters:
- None. Geometry is fixed: 64 lines, 16-byte lines, index addr[9:4], tag addr[31:10].

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- regInData  in  64  store data (right-aligned)
- regOutData  out  64  load result
- regInAddr  in  32  byte address
- regOutOK  out  2  status: 0=READY, 1=OK, 2=HOLD, 3=FAULT
- regInOE  in  1  load request
- regInWR  in  1  store request
- regInOp  in  5  [1:0] size (0=8b, 1=16b, 2=32b, 3=64b); [2] zero-extend loads; [4:3] ignored
- memInData  in  128  line data from L2
- memOutData  out  128  line data to L2 (writeback)
- memPcAddr  out  32  line address to L2, low 4 bits zero
- memPcOK  in  2  L2 status, same encoding as regOutOK
- memPcOE  out  1  line read request
- memPcWR  out  1  line write request
- memOp  out  5  L2 op; constant 5'h01 (line transfer)

Behaviour:
- Reset, synchronous:
  - all valid and dirty bits cleared; FSM to IDLE
  - memPcOE=memPcWR=0, memPcAddr=0, memOutData=0
  - regOutOK=READY, regOutData=0
- Address alignment: low bits are forced to natural alignment (size 1 clears bit0, size 2 bits[1:0], size 3 bits[2:0]). An access therefore never crosses a line.
- Byte order is little-endian within the line.
- No request (regInOE=regInWR=0): regOutOK=READY, regOutData=0, no array change.
- If both regInOE and regInWR are 1, the access is a store.
- Hit (IDLE state, line valid, tag equal):
  - regOutOK=OK in the same cycle (combinational)
  - load: regOutData = selected bytes, sign-extended to 64 bits unless regInOp[2]=1 (zero-extended); size 3 returns raw 64 bits
  - store: the selected bytes are merged into the line at the clock edge and dirty is set; other bytes are unchanged
  - a store held at OK for several cycles rewrites the same value (idempotent)
- Miss: regOutOK=HOLD and regOutData=0 until the line is present, then a normal hit follows.
- FSM IDLE:
  - on a miss with a valid, dirty victim: go to WB; memPcAddr={victim tag, index, 4'h0}, memOutData=victim line, memPcWR=1
  - on a miss otherwise: go to FILL; memPcAddr={req addr[31:4], 4'h0}, memPcOE=1
- FSM WB: hold outputs until memPcOK==OK; at that edge clear dirty, drop memPcWR, go to WAITR then FILL.
- FSM FILL: hold memPcOE until memPcOK==OK; at that edge write memInData into the line, set valid, set the new tag, clear dirty, drop memPcOE, go to WAITR then IDLE.
- FSM WAITR: no request asserted; wait until memPcOK != OK before the next state, enforcing a 4-phase handshake.
- memPcOE and memPcWR are never both 1.
- memPcOK=HOLD/READY: keep waiting, no timeout.
- memPcOK=FAULT during WB/FILL:
  - abort to IDLE through WAITR; the line is left unchanged (WB) or left invalid (FILL)
  - regOutOK=FAULT for one cycle; the next cycle retries from the miss
- Request removed mid-miss: the in-flight transaction completes and the line is filled; no response is given.
- Request changes mid-miss: the FSM finishes the current line, then re-evaluates the current request.
- Reset mid-miss: memPcOE/memPcWR drop on the next edge and all lines are invalidated.
- Hit latency is 0 cycles. A clean-miss load with an L2 that answers OK one cycle after the request sees OK about 3 cycles after the request. A dirty miss adds the WB phase.

Test Plan:
- After reset, load 32-bit at 0x00001000 (miss) -> HOLD; memPcOE=1 with memPcAddr=0x00001000. L2 returns line with bytes 0x00..0x0F and OK -> then regOutOK=OK, regOutData=0x0000000003020100.
- Store 8-bit 0x80 to 0x00001005 (hit) -> OK the same cycle. A following signed 8-bit load from 0x00001005 -> 0xFFFFFFFFFFFFFF80; with regInOp[2]=1 -> 0x0000000000000080.
- Load 32-bit from 0x00002000 (same index 0x00, different tag, dirty victim) -> memPcWR=1 with memPcAddr=0x00001000 and memOutData byte5=0x80; after OK and the READY return, a fill of 0x00002000 follows.
- 64-bit load at 0x00001003 -> treated as 0x00001000; returns 0x0706050403020100 (pre-store line).
- L2 answers FAULT during a fill -> regOutOK=FAULT for one cycle; the line stays invalid and the FSM retries.
- Reset asserted while memPcOE=1 -> the next cycle has memPcOE=0 and regOutOK=READY; a previously hit address now misses.
